comp_seq: RTL

COMP_SEQ -- requirements
Module: comp_seq

---
 rtl/comp_seq.sv | 108 ++++++++++
 1 files changed

// File: rtl/comp_seq.sv
// Sequential magnitude comparator: walks the captured operands one CHUNK-bit
// slice per cycle from the MSB end and exits at the first differing slice.
module comp_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             l,
  output logic             g,
  output logic             eq
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] TOP_IDX = IW'(NCH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] opA_q;
  logic [WIDTH-1:0] opB_q;
  logic             sgn_q;
  logic             busy_q;
  logic             done_q;
  logic             l_q;
  logic             g_q;
  logic             eq_q;

  logic [CHUNK-1:0] aSlice;
  logic [CHUNK-1:0] bSlice;
  int               base;

  // Signed compare flips the sign bit in the top slice only (offset binary),
  // so every slice can then be compared as unsigned.
  always_comb begin
    base   = int'(idx_q) * CHUNK;
    aSlice = opA_q[base +: CHUNK];
    bSlice = opB_q[base +: CHUNK];
    if (sgn_q && (idx_q == TOP_IDX)) begin
      aSlice[CHUNK-1] = ~aSlice[CHUNK-1];
      bSlice[CHUNK-1] = ~bSlice[CHUNK-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      opA_q   <= '0;
      opB_q   <= '0;
      sgn_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      l_q     <= 1'b0;
      g_q     <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            opA_q   <= a;
            opB_q   <= b;
            sgn_q   <= sgn;
            idx_q   <= TOP_IDX;
            l_q     <= 1'b0;
            g_q     <= 1'b0;
            eq_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (aSlice != bSlice) begin
            l_q     <= (aSlice < bSlice);
            g_q     <= (aSlice > bSlice);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (idx_q == '0) begin
            eq_q    <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign l    = l_q;
  assign g    = g_q;
  assign eq   = eq_q;

endmodule
